control_unit: RTL and testbench

Multi-cycle instruction sequencer for the 19-bit CPU. It drives the control bus strobes (memory enables, PC increment, register load and select, ALU opcode and mode, operand mux selects) through a fetch, decode and execute cycle for each instruction. It waits on ready handshakes from instruction and data memory and guards each wait with a timeout. It sits between the instruction register and the PC/register file/ALU/memory blocks.

---
 rtl/control_unit_if.sv | 38 +++
 rtl/control_unit.sv | 167 ++++++++++++++++
 tb/tb_control_unit.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// Control-bus bundle between the instruction sequencer and the datapath/memory blocks.
// master: the sequencer (drives strobes, samples readies); slave: the datapath/memory side.
interface control_unit_if #(
   parameter int OPCODE_W = 5
);
   logic                enable;
   logic [OPCODE_W-1:0] ir_opcode;
   logic [3:0]          flags;
   logic                im_ready;
   logic                dm_ready;

   logic                rd_en_im;
   logic                wr_en_im;
   logic                rd_en_dm;
   logic                wr_en_dm;
   logic                inc_pc;
   logic                load_reg;
   logic [2:0]          load_select;
   logic [OPCODE_W-1:0] alu_opcode;
   logic                alu_mode;
   logic                mux_sel_a;
   logic                mux_sel_b;
   logic                halted;
   logic                illegal;
   logic                bus_err;

   modport master (
      input  enable, ir_opcode, flags, im_ready, dm_ready,
      output rd_en_im, wr_en_im, rd_en_dm, wr_en_dm, inc_pc, load_reg, load_select,
             alu_opcode, alu_mode, mux_sel_a, mux_sel_b, halted, illegal, bus_err
   );

   modport slave (
      output enable, ir_opcode, flags, im_ready, dm_ready,
      input  rd_en_im, wr_en_im, rd_en_dm, wr_en_dm, inc_pc, load_reg, load_select,
             alu_opcode, alu_mode, mux_sel_a, mux_sel_b, halted, illegal, bus_err
   );
endinterface

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer driving the CPU control strobes.
// Latency: 3 cycles per ALU/branch instruction, plus one per memory wait state.
// Backpressure: holds read/write enables until im_ready/dm_ready; TIMEOUT cycles without ready -> bus_err + HALT.
module control_unit #(
   parameter int OPCODE_W = 5,
   parameter int TIMEOUT  = 15
) (
   input logic            clk,
   input logic            rst_n,
   control_unit_if.master bus
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [OPCODE_W-1:0] OP_LOGIC_MAX = OPCODE_W'(8'h0F);
   localparam logic [OPCODE_W-1:0] OP_LOAD      = OPCODE_W'(8'h10);
   localparam logic [OPCODE_W-1:0] OP_STORE     = OPCODE_W'(8'h11);
   localparam logic [OPCODE_W-1:0] OP_JMP       = OPCODE_W'(8'h12);
   localparam logic [OPCODE_W-1:0] OP_BEQ       = OPCODE_W'(8'h13);
   localparam logic [OPCODE_W-1:0] OP_BNE       = OPCODE_W'(8'h14);
   localparam logic [OPCODE_W-1:0] OP_ALUI      = OPCODE_W'(8'h15);
   localparam logic [OPCODE_W-1:0] OP_HALT      = OPCODE_W'(8'h1F);

   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, EXEC, MEM_RD, MEM_WR, BRANCH, HALT
   } state_t;

   state_t              state;
   logic [OPCODE_W-1:0] op_q;
   logic [CNT_W-1:0]    wait_cnt;
   logic                bus_err_q;

   logic   wait_ready;
   logic   timed_out;
   state_t boundary;
   logic   unused_flags;

   function automatic logic is_alu(input logic [OPCODE_W-1:0] op);
      return (op <= OP_LOGIC_MAX) || (op == OP_ALUI);
   endfunction

   function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
      return is_alu(op) || (op == OP_LOAD) || (op == OP_STORE) || (op == OP_JMP) ||
             (op == OP_BEQ) || (op == OP_BNE) || (op == OP_HALT);
   endfunction

   assign unused_flags = ^bus.flags[3:1];

   // Ready arriving in the limit cycle beats the timeout.
   always_comb begin
      wait_ready = (state == FETCH) ? bus.im_ready : bus.dm_ready;
      timed_out  = (state inside {FETCH, MEM_RD, MEM_WR}) && !wait_ready &&
                   (wait_cnt == CNT_W'(TIMEOUT - 1));
      boundary   = bus.enable ? FETCH : IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         op_q      <= '0;
         wait_cnt  <= '0;
         bus_err_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               wait_cnt <= '0;
               if (bus.enable) state <= FETCH;
            end
            FETCH: begin
               if (bus.im_ready) begin
                  state    <= DECODE;
                  wait_cnt <= '0;
               end else if (timed_out) begin
                  state     <= HALT;
                  bus_err_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            DECODE: begin
               op_q     <= bus.ir_opcode;
               wait_cnt <= '0;
               if (is_alu(bus.ir_opcode))                                 state <= EXEC;
               else if (bus.ir_opcode == OP_LOAD)                         state <= MEM_RD;
               else if (bus.ir_opcode == OP_STORE)                        state <= MEM_WR;
               else if (bus.ir_opcode inside {OP_JMP, OP_BEQ, OP_BNE})    state <= BRANCH;
               else if (bus.ir_opcode == OP_HALT)                         state <= HALT;
               else                                                       state <= boundary;
            end
            EXEC, BRANCH: begin
               wait_cnt <= '0;
               state    <= boundary;
            end
            MEM_RD, MEM_WR: begin
               if (bus.dm_ready) begin
                  state    <= boundary;
                  wait_cnt <= '0;
               end else if (timed_out) begin
                  state     <= HALT;
                  bus_err_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            HALT:    state <= HALT;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus.rd_en_im    = 1'b0;
      bus.wr_en_im    = 1'b0;
      bus.rd_en_dm    = 1'b0;
      bus.wr_en_dm    = 1'b0;
      bus.inc_pc      = 1'b0;
      bus.load_reg    = 1'b0;
      bus.load_select = 3'b000;
      bus.alu_opcode  = '0;
      bus.alu_mode    = 1'b0;
      bus.mux_sel_a   = 1'b0;
      bus.mux_sel_b   = 1'b0;
      bus.halted      = 1'b0;
      bus.illegal     = 1'b0;
      bus.bus_err     = bus_err_q;
      case (state)
         FETCH: begin
            bus.rd_en_im = 1'b1;
            if (bus.im_ready) begin
               bus.load_reg    = 1'b1;
               bus.load_select = 3'b001;
            end
         end
         DECODE: begin
            bus.inc_pc  = 1'b1;
            bus.illegal = !is_legal(bus.ir_opcode);
         end
         EXEC: begin
            bus.load_reg    = 1'b1;
            bus.load_select = 3'b100;
            if (op_q == OP_ALUI) begin
               bus.mux_sel_b = 1'b1;
            end else begin
               bus.alu_opcode = op_q;
               bus.alu_mode   = op_q[3];
            end
         end
         MEM_RD: begin
            bus.rd_en_dm = 1'b1;
            if (bus.dm_ready) begin
               bus.load_reg    = 1'b1;
               bus.load_select = 3'b010;
            end
         end
         MEM_WR: bus.wr_en_dm = 1'b1;
         BRANCH: begin
            if ((op_q == OP_JMP) || ((op_q == OP_BEQ) && bus.flags[0]) ||
                ((op_q == OP_BNE) && !bus.flags[0])) begin
               bus.load_reg = 1'b1;
            end
         end
         HALT:    bus.halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle stimulus/expected-strobe tables per scenario.
module tb_control_unit;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   control_unit_if #(.OPCODE_W(5)) bus ();

   control_unit #(.OPCODE_W(5), .TIMEOUT(15)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       en;
      logic       imr;
      logic       dmr;
      logic [4:0] ir;
      logic [3:0] fl;
      logic [19:0] e;
   } vec_t;

   // Layout: rim wim rdm wdm inc ld sel[3] aop[5] am msa msb hlt ill berr
   function automatic logic [19:0] ev(input logic rim, rdm, wdm, inc, ld, input logic [2:0] sel,
                                      input logic [4:0] aop, input logic am, msb, hlt, ill, berr);
      return {rim, 1'b0, rdm, wdm, inc, ld, sel, aop, am, 1'b0, msb, hlt, ill, berr};
   endfunction

   function automatic logic [19:0] obs();
      return {bus.rd_en_im, bus.wr_en_im, bus.rd_en_dm, bus.wr_en_dm, bus.inc_pc, bus.load_reg,
              bus.load_select, bus.alu_opcode, bus.alu_mode, bus.mux_sel_a, bus.mux_sel_b,
              bus.halted, bus.illegal, bus.bus_err};
   endfunction

   function automatic vec_t mk(input logic en, imr, dmr, input logic [4:0] ir,
                               input logic [3:0] fl, input logic [19:0] e);
      vec_t t;
      t.en = en; t.imr = imr; t.dmr = dmr; t.ir = ir; t.fl = fl; t.e = e;
      return t;
   endfunction

   logic [19:0] e_idl, e_fl, e_fw, e_dc, e_di, e_hl, e_hb, e_rd, e_rdl, e_wr, e_brl, e_imm;

   function automatic logic [19:0] e_ex(input logic [4:0] op);
      return ev(0, 0, 0, 0, 1, 3'b100, op, op[3], 0, 0, 0, 0);
   endfunction

   task automatic restart();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      bus.enable = 1'b1; bus.im_ready = 1'b1; bus.dm_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (obs() !== 20'h0) begin
            errors++;
            $display("FAIL reset_hold cyc%0d got=%05h exp=%05h", i, obs(), 20'h0);
         end
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (obs() !== e_idl) begin
         errors++;
         $display("FAIL reset_idle got=%05h exp=%05h", obs(), e_idl);
      end
      @(negedge clk);
      checks++;
      if (obs() !== e_fl) begin
         errors++;
         $display("FAIL reset_first_fetch got=%05h exp=%05h", obs(), e_fl);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_alu();
      vec_t v[$];
      v.push_back(mk(1, 1, 1, 5'h03, 4'h0, e_idl));
      v.push_back(mk(1, 1, 1, 5'h03, 4'h0, e_fl));
      v.push_back(mk(1, 1, 1, 5'h03, 4'h0, e_dc));
      v.push_back(mk(1, 1, 1, 5'h03, 4'h0, e_ex(5'h03)));
      v.push_back(mk(1, 1, 1, 5'h03, 4'h0, e_fl));
      restart();
      foreach (v[i]) begin
         bus.enable = v[i].en; bus.im_ready = v[i].imr; bus.dm_ready = v[i].dmr;
         bus.ir_opcode = v[i].ir; bus.flags = v[i].fl;
         @(negedge clk);
         checks++;
         if (obs() !== v[i].e) begin
            errors++;
            $display("FAIL alu cyc%0d got=%05h exp=%05h", i, obs(), v[i].e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      vec_t v[$];
      v.push_back(mk(1, 1, 1, 5'h0A, 4'h0, e_idl));
      v.push_back(mk(1, 1, 1, 5'h0A, 4'h0, e_fl));
      v.push_back(mk(1, 1, 1, 5'h0A, 4'h0, e_dc));
      v.push_back(mk(1, 1, 1, 5'h0A, 4'h0, e_ex(5'h0A)));
      v.push_back(mk(1, 1, 1, 5'h15, 4'h0, e_fl));
      v.push_back(mk(1, 1, 1, 5'h15, 4'h0, e_dc));
      v.push_back(mk(1, 1, 1, 5'h15, 4'h0, e_imm));
      v.push_back(mk(1, 1, 1, 5'h12, 4'h0, e_fl));
      v.push_back(mk(1, 1, 1, 5'h12, 4'h0, e_dc));
      v.push_back(mk(1, 1, 1, 5'h12, 4'h0, e_brl));
      v.push_back(mk(1, 1, 1, 5'h12, 4'h0, e_fl));
      restart();
      foreach (v[i]) begin
         bus.enable = v[i].en; bus.im_ready = v[i].imr; bus.dm_ready = v[i].dmr;
         bus.ir_opcode = v[i].ir; bus.flags = v[i].fl;
         @(negedge clk);
         checks++;
         if (obs() !== v[i].e) begin
            errors++;
            $display("FAIL back_to_back cyc%0d got=%05h exp=%05h", i, obs(), v[i].e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_wait();
      vec_t v[$];
      v.push_back(mk(1, 1, 0, 5'h10, 4'h0, e_idl));
      v.push_back(mk(1, 1, 0, 5'h10, 4'h0, e_fl));
      v.push_back(mk(1, 1, 0, 5'h10, 4'h0, e_dc));
      for (int k = 0; k < 4; k++) v.push_back(mk(1, 1, 0, 5'h10, 4'h0, e_rd));
      v.push_back(mk(1, 1, 1, 5'h10, 4'h0, e_rdl));
      v.push_back(mk(1, 1, 1, 5'h10, 4'h0, e_fl));
      restart();
      foreach (v[i]) begin
         bus.enable = v[i].en; bus.im_ready = v[i].imr; bus.dm_ready = v[i].dmr;
         bus.ir_opcode = v[i].ir; bus.flags = v[i].fl;
         @(negedge clk);
         checks++;
         if (obs() !== v[i].e) begin
            errors++;
            $display("FAIL load_wait cyc%0d got=%05h exp=%05h", i, obs(), v[i].e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_store_enable_drop();
      vec_t v[$];
      v.push_back(mk(1, 1, 0, 5'h11, 4'h0, e_idl));
      v.push_back(mk(1, 1, 0, 5'h11, 4'h0, e_fl));
      v.push_back(mk(1, 1, 0, 5'h11, 4'h0, e_dc));
      v.push_back(mk(0, 1, 0, 5'h11, 4'h0, e_wr));
      v.push_back(mk(0, 1, 0, 5'h11, 4'h0, e_wr));
      v.push_back(mk(0, 1, 1, 5'h11, 4'h0, e_wr));
      v.push_back(mk(0, 1, 0, 5'h11, 4'h0, e_idl));
      v.push_back(mk(0, 1, 0, 5'h11, 4'h0, e_idl));
      restart();
      foreach (v[i]) begin
         bus.enable = v[i].en; bus.im_ready = v[i].imr; bus.dm_ready = v[i].dmr;
         bus.ir_opcode = v[i].ir; bus.flags = v[i].fl;
         @(negedge clk);
         checks++;
         if (obs() !== v[i].e) begin
            errors++;
            $display("FAIL store_en_drop cyc%0d got=%05h exp=%05h", i, obs(), v[i].e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch();
      vec_t v[$];
      v.push_back(mk(1, 1, 1, 5'h13, 4'h1, e_idl));
      v.push_back(mk(1, 1, 1, 5'h13, 4'h1, e_fl));
      v.push_back(mk(1, 1, 1, 5'h13, 4'h1, e_dc));
      v.push_back(mk(1, 1, 1, 5'h13, 4'h1, e_brl));
      v.push_back(mk(1, 1, 1, 5'h13, 4'hE, e_fl));
      v.push_back(mk(1, 1, 1, 5'h13, 4'hE, e_dc));
      v.push_back(mk(1, 1, 1, 5'h13, 4'hE, 20'h0));
      v.push_back(mk(1, 1, 1, 5'h14, 4'h1, e_fl));
      v.push_back(mk(1, 1, 1, 5'h14, 4'h1, e_dc));
      v.push_back(mk(1, 1, 1, 5'h14, 4'h1, 20'h0));
      v.push_back(mk(1, 1, 1, 5'h14, 4'hE, e_fl));
      v.push_back(mk(1, 1, 1, 5'h14, 4'hE, e_dc));
      v.push_back(mk(1, 1, 1, 5'h14, 4'hE, e_brl));
      v.push_back(mk(1, 1, 1, 5'h14, 4'hE, e_fl));
      restart();
      foreach (v[i]) begin
         bus.enable = v[i].en; bus.im_ready = v[i].imr; bus.dm_ready = v[i].dmr;
         bus.ir_opcode = v[i].ir; bus.flags = v[i].fl;
         @(negedge clk);
         checks++;
         if (obs() !== v[i].e) begin
            errors++;
            $display("FAIL branch cyc%0d got=%05h exp=%05h", i, obs(), v[i].e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal();
      vec_t v[$];
      v.push_back(mk(1, 1, 1, 5'h1A, 4'h0, e_idl));
      v.push_back(mk(1, 1, 1, 5'h1A, 4'h0, e_fl));
      v.push_back(mk(1, 1, 1, 5'h1A, 4'h0, e_di));
      v.push_back(mk(1, 1, 1, 5'h1A, 4'h0, e_fl));
      v.push_back(mk(1, 1, 1, 5'h1A, 4'h0, e_di));
      v.push_back(mk(1, 1, 1, 5'h16, 4'h0, e_fl));
      v.push_back(mk(1, 1, 1, 5'h16, 4'h0, e_di));
      v.push_back(mk(1, 1, 1, 5'h16, 4'h0, e_fl));
      restart();
      foreach (v[i]) begin
         bus.enable = v[i].en; bus.im_ready = v[i].imr; bus.dm_ready = v[i].dmr;
         bus.ir_opcode = v[i].ir; bus.flags = v[i].fl;
         @(negedge clk);
         checks++;
         if (obs() !== v[i].e) begin
            errors++;
            $display("FAIL illegal cyc%0d got=%05h exp=%05h", i, obs(), v[i].e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_halt();
      vec_t v[$];
      v.push_back(mk(1, 1, 1, 5'h1F, 4'h0, e_idl));
      v.push_back(mk(1, 1, 1, 5'h1F, 4'h0, e_fl));
      v.push_back(mk(1, 1, 1, 5'h1F, 4'h0, e_dc));
      for (int k = 0; k < 22; k++) v.push_back(mk(1, 1, 1, 5'h03, 4'h1, e_hl));
      restart();
      foreach (v[i]) begin
         bus.enable = v[i].en; bus.im_ready = v[i].imr; bus.dm_ready = v[i].dmr;
         bus.ir_opcode = v[i].ir; bus.flags = v[i].fl;
         @(negedge clk);
         checks++;
         if (obs() !== v[i].e) begin
            errors++;
            $display("FAIL halt cyc%0d got=%05h exp=%05h", i, obs(), v[i].e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_timeout();
      vec_t v[$];
      v.push_back(mk(1, 0, 0, 5'h03, 4'h0, e_idl));
      for (int k = 0; k < 15; k++) v.push_back(mk(1, 0, 0, 5'h03, 4'h0, e_fw));
      for (int k = 0; k < 3; k++)  v.push_back(mk(1, 1, 1, 5'h03, 4'h0, e_hb));
      restart();
      foreach (v[i]) begin
         bus.enable = v[i].en; bus.im_ready = v[i].imr; bus.dm_ready = v[i].dmr;
         bus.ir_opcode = v[i].ir; bus.flags = v[i].fl;
         @(negedge clk);
         checks++;
         if (obs() !== v[i].e) begin
            errors++;
            $display("FAIL im_timeout cyc%0d got=%05h exp=%05h", i, obs(), v[i].e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_timeout_edge();
      vec_t v[$];
      v.push_back(mk(1, 0, 0, 5'h03, 4'h0, e_idl));
      for (int k = 0; k < 14; k++) v.push_back(mk(1, 0, 0, 5'h03, 4'h0, e_fw));
      v.push_back(mk(1, 1, 0, 5'h03, 4'h0, e_fl));
      v.push_back(mk(1, 1, 0, 5'h03, 4'h0, e_dc));
      v.push_back(mk(1, 1, 0, 5'h03, 4'h0, e_ex(5'h03)));
      v.push_back(mk(1, 1, 0, 5'h03, 4'h0, e_fl));
      restart();
      foreach (v[i]) begin
         bus.enable = v[i].en; bus.im_ready = v[i].imr; bus.dm_ready = v[i].dmr;
         bus.ir_opcode = v[i].ir; bus.flags = v[i].fl;
         @(negedge clk);
         checks++;
         if (obs() !== v[i].e) begin
            errors++;
            $display("FAIL timeout_edge cyc%0d got=%05h exp=%05h", i, obs(), v[i].e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_dm_timeout();
      vec_t v[$];
      v.push_back(mk(1, 1, 0, 5'h11, 4'h0, e_idl));
      v.push_back(mk(1, 1, 0, 5'h11, 4'h0, e_fl));
      v.push_back(mk(1, 1, 0, 5'h11, 4'h0, e_dc));
      for (int k = 0; k < 15; k++) v.push_back(mk(1, 1, 0, 5'h11, 4'h0, e_wr));
      v.push_back(mk(1, 1, 1, 5'h11, 4'h0, e_hb));
      v.push_back(mk(1, 1, 1, 5'h11, 4'h0, e_hb));
      restart();
      foreach (v[i]) begin
         bus.enable = v[i].en; bus.im_ready = v[i].imr; bus.dm_ready = v[i].dmr;
         bus.ir_opcode = v[i].ir; bus.flags = v[i].fl;
         @(negedge clk);
         checks++;
         if (obs() !== v[i].e) begin
            errors++;
            $display("FAIL dm_timeout cyc%0d got=%05h exp=%05h", i, obs(), v[i].e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_async_reset();
      restart();
      bus.enable = 1'b1; bus.im_ready = 1'b0; bus.dm_ready = 1'b0; bus.ir_opcode = 5'h03;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (obs() !== e_fw) begin
         errors++;
         $display("FAIL async_rst_pre got=%05h exp=%05h", obs(), e_fw);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (obs() !== 20'h0) begin
         errors++;
         $display("FAIL async_rst_drop got=%05h exp=%05h", obs(), 20'h0);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (obs() !== e_idl) begin
         errors++;
         $display("FAIL async_rst_idle got=%05h exp=%05h", obs(), e_idl);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b1;
      bus.enable = 1'b0; bus.ir_opcode = 5'h00; bus.flags = 4'h0;
      bus.im_ready = 1'b0; bus.dm_ready = 1'b0;
      e_idl = 20'h0;
      e_fl  = ev(1, 0, 0, 0, 1, 3'b001, 5'h00, 0, 0, 0, 0, 0);
      e_fw  = ev(1, 0, 0, 0, 0, 3'b000, 5'h00, 0, 0, 0, 0, 0);
      e_dc  = ev(0, 0, 0, 1, 0, 3'b000, 5'h00, 0, 0, 0, 0, 0);
      e_di  = ev(0, 0, 0, 1, 0, 3'b000, 5'h00, 0, 0, 0, 1, 0);
      e_hl  = ev(0, 0, 0, 0, 0, 3'b000, 5'h00, 0, 0, 1, 0, 0);
      e_hb  = ev(0, 0, 0, 0, 0, 3'b000, 5'h00, 0, 0, 1, 0, 1);
      e_rd  = ev(0, 1, 0, 0, 0, 3'b000, 5'h00, 0, 0, 0, 0, 0);
      e_rdl = ev(0, 1, 0, 0, 1, 3'b010, 5'h00, 0, 0, 0, 0, 0);
      e_wr  = ev(0, 0, 1, 0, 0, 3'b000, 5'h00, 0, 0, 0, 0, 0);
      e_brl = ev(0, 0, 0, 0, 1, 3'b000, 5'h00, 0, 0, 0, 0, 0);
      e_imm = ev(0, 0, 0, 0, 1, 3'b100, 5'h00, 0, 1, 0, 0, 0);

      test_reset();
      test_alu();
      test_back_to_back();
      test_load_wait();
      test_store_enable_drop();
      test_branch();
      test_illegal();
      test_halt();
      test_timeout();
      test_timeout_edge();
      test_dm_timeout();
      test_async_reset();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
